// File: rtl/my_fwft_ram_fifo.sv
// my_fwft_ram_fifo: single-clock first-word-fall-through FIFO on a distributed
// RAM with an asynchronous read port. The head entry is always presented on
// o_rddata while the FIFO is non-empty. Any DEPTH >= 2 is supported.
// A single occupancy counter drives every status flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_fifoen                 enable; when low, all state holds and strobes are ignored
//   i_flush                  synchronous empty (RAM contents untouched, error flags kept)
//   i_clr_err                clears the sticky o_ovf / o_udf flags
//   i_wren, i_wrdata         write request and data
//   o_full, o_afull, o_ovf   write-side status
//   i_rden                   pop the head entry
//   o_rddata                 head-of-queue data, valid while o_empty is low
//   o_empty, o_aempty, o_udf read-side status
//   o_count                  occupancy, 0..DEPTH
module my_fwft_ram_fifo #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = DEPTH - 1,
   parameter int unsigned AE_THRESH = 1,
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_fifoen,
   input  logic              i_flush,
   input  logic              i_clr_err,
   input  logic              i_wren,
   input  logic [DATA_W-1:0] i_wrdata,
   output logic              o_full,
   output logic              o_afull,
   output logic              o_ovf,
   input  logic              i_rden,
   output logic [DATA_W-1:0] o_rddata,
   output logic              o_empty,
   output logic              o_aempty,
   output logic              o_udf,
   output logic [CW-1:0]     o_count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wrptr;
   logic [PW-1:0]     rdptr;
   logic [CW-1:0]     count;
   logic              rd_acc;
   logic              wr_acc;
   logic              ovf_set;
   logic              udf_set;

   // Explicit wrap so non-power-of-two depths never address past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Status flags are pure decodes of the registered count.
   assign o_count  = count;
   assign o_empty  = (count == '0);
   assign o_full   = (count == CW'(DEPTH));
   assign o_afull  = (count >= CW'(AF_THRESH));
   assign o_aempty = (count <= CW'(AE_THRESH));

   // A write into a full FIFO is legal only when the same cycle frees the head slot.
   assign rd_acc  = i_fifoen & i_rden & ~o_empty;
   assign wr_acc  = i_fifoen & i_wren & (~o_full | rd_acc);
   assign ovf_set = i_fifoen & i_wren & ~wr_acc;
   assign udf_set = i_fifoen & i_rden & o_empty;

   // Asynchronous read of the head entry (first-word fall-through).
   assign o_rddata = mem[rdptr];

   // Storage: no reset, written only on an accepted write outside reset/flush.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush && wr_acc) begin
         mem[wrptr] <= i_wrdata;
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrptr <= '0;
         rdptr <= '0;
         count <= '0;
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else if (i_flush) begin
         wrptr <= '0;
         rdptr <= '0;
         count <= '0;
      end else if (i_fifoen) begin
         if (wr_acc) wrptr <= ptr_inc(wrptr);
         if (rd_acc) rdptr <= ptr_inc(rdptr);
         if (wr_acc && !rd_acc) begin
            count <= count + CW'(1);
         end else if (rd_acc && !wr_acc) begin
            count <= count - CW'(1);
         end
         // A new error event beats a coincident clear.
         if (ovf_set) begin
            o_ovf <= 1'b1;
         end else if (i_clr_err) begin
            o_ovf <= 1'b0;
         end
         if (udf_set) begin
            o_udf <= 1'b1;
         end else if (i_clr_err) begin
            o_udf <= 1'b0;
         end
      end
   end

endmodule
